// File: rtl/div_if.sv
// Operand/result bundle between the divider and its requester.
// The requester drives start/data_in; the divider drives status and results.
interface div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  div_by_zero,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output div_by_zero,
    output quotient,
    output remainder
  );
endinterface

// File: rtl/div_controller_dp.sv
// Sequential unsigned divider by repeated subtraction; operands arrive serially
// on data_in (dividend, then divisor) and the controller FSM shares this module.
module div_controller_dp #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] b_r;
  logic             dbz_r;
  logic             can_sub;

  // Full-width unsigned compare; the subtraction below is guarded by it, so R never underflows.
  assign can_sub = (r_r >= b_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_r   <= '0;
      r_r   <= '0;
      b_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD_A;
            dbz_r <= 1'b0;
          end
        end
        LOAD_A: begin
          r_r   <= bus.data_in;
          q_r   <= '0;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b_r   <= bus.data_in;
          state <= CHECK;
        end
        CHECK: begin
          if (b_r == '0) begin
            dbz_r <= 1'b1;
            state <= DONE;
          end else begin
            state <= SUB;
          end
        end
        SUB: begin
          if (can_sub) begin
            r_r <= r_r - b_r;
            q_r <= q_r + WIDTH'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // Results are held until start drops; no automatic restart.
          if (!bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == LOAD_A) || (state == LOAD_B) ||
                           (state == CHECK)  || (state == SUB);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;

endmodule

// File: tb/tb_div_controller_dp.sv
// Bench for div_controller_dp: vector table driven through a scoreboard,
// plus hand sequences for mid-operation reset and start held through DONE.
module tb_div_controller_dp;

  localparam int W = 16;
  localparam int MAX_EDGES = 70000;

  logic clk;
  logic rst;

  div_if #(.WIDTH(W)) bus ();

  div_controller_dp #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one operation, pushes its expectation, waits for done and scores it.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'hDEAD;
    @(posedge clk);            // edge 1: start sampled in IDLE
    @(negedge clk);
    chk({tag, " busy_in_load"}, {31'd0, bus.busy}, 32'd1);
    bus.start   = 1'b0;
    bus.data_in = a;
    @(posedge clk);            // edge 2: LOAD_A
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);            // edge 3: LOAD_B
    @(negedge clk);
    bus.data_in = W'($urandom);
    n = 3;
    seen = 1'b0;
    while (!seen && n < MAX_EDGES) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    got = sb.pop_front();
    if (!seen) begin
      chk({tag, " done_timeout"}, 32'(n), 32'(got.lat));
      do_reset();
    end else begin
      chk({tag, " latency"},   32'(n), 32'(got.lat));
      chk({tag, " quotient"},  {16'd0, bus.quotient}, {16'd0, got.q});
      chk({tag, " remainder"}, {16'd0, bus.remainder}, {16'd0, got.r});
      chk({tag, " dbz"},       {31'd0, bus.div_by_zero}, {31'd0, got.dbz});
      chk({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      @(posedge clk);          // start low in DONE -> IDLE
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   n;
    bit   seen;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;

    // Fixed vectors: {a, b, q, r, dbz, latency}
    vecs.push_back('{16'd17,    16'd5,     16'd3,     16'd2,   1'b0, 8});
    vecs.push_back('{16'd5,     16'd17,    16'd0,     16'd5,   1'b0, 5});
    vecs.push_back('{16'd0,     16'd7,     16'd0,     16'd0,   1'b0, 5});
    vecs.push_back('{16'd100,   16'd0,     16'd0,     16'd100, 1'b1, 4});
    vecs.push_back('{16'd20,    16'd4,     16'd5,     16'd0,   1'b0, 10});
    vecs.push_back('{16'd65535, 16'd65535, 16'd1,     16'd0,   1'b0, 6});
    vecs.push_back('{16'd65535, 16'd1,     16'd65535, 16'd0,   1'b0, 65540});
    for (int i = 0; i < 4; i++) begin
      v.a = W'($urandom);
      v.b = W'($urandom_range(65535, 300));
      v.q = v.a / v.b;
      v.r = v.a % v.b;
      v.dbz = 1'b0;
      v.lat = 5 + int'(v.q);
      vecs.push_back(v);
    end

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset quotient",  {16'd0, bus.quotient}, 32'd0);
    chk("reset remainder", {16'd0, bus.remainder}, 32'd0);
    chk("reset busy",      {31'd0, bus.busy}, 32'd0);
    chk("reset done",      {31'd0, bus.done}, 32'd0);
    chk("reset dbz",       {31'd0, bus.div_by_zero}, 32'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v.a, v.b, v.q, v.r, v.dbz, v.lat);
    end

    // Reset during SUB with Q=1, then a fresh operation.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data_in = 16'd17;
    @(negedge clk);
    bus.data_in = 16'd5;
    @(negedge clk);            // CHECK
    @(negedge clk);            // SUB, Q=0
    @(negedge clk);            // SUB, Q=1
    chk("midrst q_before", {16'd0, bus.quotient}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst quotient",  {16'd0, bus.quotient}, 32'd0);
    chk("midrst remainder", {16'd0, bus.remainder}, 32'd0);
    chk("midrst busy",      {31'd0, bus.busy}, 32'd0);
    chk("midrst done",      {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst idle_busy", {31'd0, bus.busy}, 32'd0);
    run_op("after_rst", 16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 10);

    // Start held high through DONE: results hold, no reload.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.data_in = 16'd17;
    @(negedge clk);
    bus.data_in = 16'd5;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk("hold reached_done", {31'd0, seen}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.data_in = W'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("hold done c%0d", k), {31'd0, bus.done}, 32'd1);
      chk($sformatf("hold q c%0d", k), {16'd0, bus.quotient}, 32'd3);
      chk($sformatf("hold r c%0d", k), {16'd0, bus.remainder}, 32'd2);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold released done", {31'd0, bus.done}, 32'd0);
    chk("hold released busy", {31'd0, bus.busy}, 32'd0);
    run_op("restart", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
